// File: rtl/cla16_seq.sv
// 16-bit sequential adder. One registered 4-bit carry-lookahead slice is reused
// for four nibbles, with a valid/ready handshake on both the input and output sides.

module CLA4bit (
    input  logic       clk,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [3:0] g, p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    // No reset: the sequencer never consumes this register before loading it.
    always_ff @(posedge clk) begin
        S    <= p ^ c[3:0];
        Cout <= c[4];
    end
endmodule

module cla16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic [1:0]  k_q;
    logic [15:0] a_q, b_q;
    logic        cin_q;
    logic [15:0] sum_q;
    logic        cout_q, ovf_q, out_valid_q;

    logic [3:0]  cla_a_d, cla_b_d, cla_s;
    logic        cla_cin_d, cla_cout;

    CLA4bit u_cla (
        .clk  (clk),
        .A    (cla_a_d),
        .B    (cla_b_d),
        .Cin  (cla_cin_d),
        .S    (cla_s),
        .Cout (cla_cout)
    );

    always_comb begin
        cla_a_d = a_q[3:0];
        cla_b_d = b_q[3:0];
        case (k_q)
            2'd0: begin cla_a_d = a_q[3:0];   cla_b_d = b_q[3:0];   end
            2'd1: begin cla_a_d = a_q[7:4];   cla_b_d = b_q[7:4];   end
            2'd2: begin cla_a_d = a_q[11:8];  cla_b_d = b_q[11:8];  end
            default: begin cla_a_d = a_q[15:12]; cla_b_d = b_q[15:12]; end
        endcase
        // Nibble 0 must ignore the stale slice carry left over from any earlier op.
        cla_cin_d = (k_q == 2'd0) ? cin_q : cla_cout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            cin_q       <= 1'b0;
            sum_q       <= 16'h0000;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        cin_q   <= cin;
                        k_q     <= 2'd0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // The slice output now holds the nibble presented last cycle.
                    case (k_q)
                        2'd1: sum_q[3:0]  <= cla_s;
                        2'd2: sum_q[7:4]  <= cla_s;
                        2'd3: sum_q[11:8] <= cla_s;
                        default: ;
                    endcase
                    k_q <= k_q + 2'd1;
                    if (k_q == 2'd3) state_q <= DRAIN;
                end
                DRAIN: begin
                    sum_q[15:12] <= cla_s;
                    cout_q       <= cla_cout;
                    ovf_q        <= (a_q[15] == b_q[15]) && (cla_s[3] != a_q[15]);
                    out_valid_q  <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla16_seq.sv
// Directed bench for cla16_seq: results, exact latency, hold in DONE, reset abort.

module tb_cla16_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout, ovf;

    int checks = 0;
    int errors = 0;

    cla16_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set (in_ready must already be high), then check latency and result.
    task automatic start_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic ci, input bit scramble,
                            input logic [15:0] es, input logic ec, input logic eo);
        a = av; b = bv; cin = ci; in_valid = 1'b1;
        check({tag, "_rdy_pre"}, {16'h0, in_ready}, 17'h1);
        step();
        in_valid = 1'b0;
        check({tag, "_rdy_busy"}, {16'h0, in_ready}, 17'h0);
        for (int i = 1; i <= 5; i++) begin
            if (scramble) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
            step();
            check({tag, "_lat"}, {16'h0, out_valid}, {16'h0, 1'(i == 5)});
        end
        check({tag, "_sum"},  {1'b0, sum},   {1'b0, es});
        check({tag, "_cout"}, {16'h0, cout}, {16'h0, ec});
        check({tag, "_ovf"},  {16'h0, ovf},  {16'h0, eo});
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ov_clr"}, {16'h0, out_valid}, 17'h0);
        check({tag, "_rdy_back"}, {16'h0, in_ready}, 17'h1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0; b = 16'h0; cin = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_rdy",  {16'h0, in_ready},  17'h1);
        check("rst_ov",   {16'h0, out_valid}, 17'h0);
        check("rst_sum",  {1'b0, sum},        17'h0);
        check("rst_cout", {16'h0, cout},      17'h0);
        check("rst_ovf",  {16'h0, ovf},       17'h0);

        start_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        finish_op("basic");

        start_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        finish_op("ripple");

        start_op("posovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        finish_op("posovf");

        start_op("negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Stay in DONE with a new operand set offered and no consumer.
        a = 16'h1111; b = 16'h2222; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_sum",  {1'b0, sum},        17'h0);
            check("hold_cout", {16'h0, cout},      17'h1);
            check("hold_ovf",  {16'h0, ovf},       17'h1);
            check("hold_ov",   {16'h0, out_valid}, 17'h1);
            check("hold_rdy",  {16'h0, in_ready},  17'h0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hs_ov",  {16'h0, out_valid}, 17'h0);
        check("hs_rdy", {16'h0, in_ready},  17'h1);
        start_op("after_hold", 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0);
        finish_op("after_hold");

        // Abort in RUN k=2.
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_ov",  {16'h0, out_valid}, 17'h0);
        check("abort_rdy", {16'h0, in_ready},  17'h1);
        check("abort_sum", {1'b0, sum},        17'h0);
        start_op("post_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        finish_op("post_rst");

        start_op("scramble", 16'h0001, 16'h0002, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b0);
        finish_op("scramble");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
